// File: rtl/ip_tx_arbiter_pkg.sv
// rtl/ip_tx_arbiter_pkg.sv - shared types and widths for the IPv4 transmit arbiter
// Purpose: address/message widths, arbiter state encoding and the latched
//          recipient record handed to the IPv4 transmitter.
// Ports:   none (package).
package infernet_net_pkg;

    localparam int IP_ADDR_WIDTH    = 32;
    localparam int MAC_ADDR_WIDTH   = 48;
    localparam int ACCEL_DATA_WIDTH = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } tx_arb_state_t;

    typedef struct packed {
        logic [IP_ADDR_WIDTH-1:0]    ip;
        logic [MAC_ADDR_WIDTH-1:0]   mac;
        logic [ACCEL_DATA_WIDTH-1:0] message;
    } recipient_t;

endpackage

// File: rtl/ip_tx_arbiter_if.sv
// rtl/ip_tx_arbiter_if.sv - requester, transmitter and MAC-monitor signal bundle
// Purpose: groups every non-clock/reset signal of ip_tx_arbiter.
// Ports:   master = requesters/transmitter side, slave = arbiter side.
interface ip_tx_arbiter_if
    import infernet_net_pkg::*;
#(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]                  REQ_VALID;
    logic [NUM_REQ-1:0]                  REQ_READY;
    logic [NUM_REQ*IP_ADDR_WIDTH-1:0]    REQ_IP_ADDRESS;
    logic [NUM_REQ*MAC_ADDR_WIDTH-1:0]   REQ_MAC_ADDRESS;
    logic [NUM_REQ*ACCEL_DATA_WIDTH-1:0] REQ_MESSAGE;
    logic [IP_ADDR_WIDTH-1:0]            RECIPIENT_IP_ADDRESS;
    logic [MAC_ADDR_WIDTH-1:0]           RECIPIENT_MAC_ADDRESS;
    logic [ACCEL_DATA_WIDTH-1:0]         RECIPIENT_MESSAGE;
    logic                                START_IP_TXN;
    logic                                READY_FOR_SEND;
    logic                                MAC_DATA_VALID;
    logic                                MAC_DATA_READY;
    logic                                MAC_DATA_LAST;
    logic [NUM_REQ-1:0]                  TXN_DONE;
    logic                                TIMEOUT_ERROR;
    logic                                CLEAR_ERROR;

    modport master (
        output REQ_VALID, REQ_IP_ADDRESS, REQ_MAC_ADDRESS, REQ_MESSAGE,
               READY_FOR_SEND, MAC_DATA_VALID, MAC_DATA_READY, MAC_DATA_LAST,
               CLEAR_ERROR,
        input  REQ_READY, RECIPIENT_IP_ADDRESS, RECIPIENT_MAC_ADDRESS,
               RECIPIENT_MESSAGE, START_IP_TXN, TXN_DONE, TIMEOUT_ERROR
    );

    modport slave (
        input  REQ_VALID, REQ_IP_ADDRESS, REQ_MAC_ADDRESS, REQ_MESSAGE,
               READY_FOR_SEND, MAC_DATA_VALID, MAC_DATA_READY, MAC_DATA_LAST,
               CLEAR_ERROR,
        output REQ_READY, RECIPIENT_IP_ADDRESS, RECIPIENT_MAC_ADDRESS,
               RECIPIENT_MESSAGE, START_IP_TXN, TXN_DONE, TIMEOUT_ERROR
    );

endinterface

// File: rtl/ip_tx_arbiter_rr_arbiter.sv
// rtl/ip_tx_arbiter_rr_arbiter.sv - combinational round-robin pick
// Purpose: chooses the first set request scanning upward from ptr+1 with wrap.
// Ports:   req (request vector), ptr (last winner), grant (one-hot),
//          grant_idx (binary index of grant), any (some request set).
module rr_arbiter #(
    parameter  int N     = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   rot;
    int             start;
    int             pick;
    int             idx;

    always_comb begin
        start     = int'(ptr) + 1;
        if (start >= N) begin
            start = 0;
        end
        // Rotate so position 0 holds the highest-priority requester.
        req_dbl   = {req, req} >> start;
        rot       = req_dbl[N-1:0];
        pick      = 0;
        any       = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                pick = k;
                any  = 1'b1;
            end
        end
        // Undo the rotation to recover the real requester index.
        idx       = start + pick;
        if (idx >= N) begin
            idx = idx - N;
        end
        grant_idx = IDX_W'(idx);
        grant     = '0;
        for (int k = 0; k < N; k++) begin
            grant[k] = any && (k == idx);
        end
    end

endmodule

// File: rtl/ip_tx_arbiter.sv
// rtl/ip_tx_arbiter.sv - round-robin sharing of the IPv4 transmitter
// Purpose: grants one requester at a time, latches its recipient fields for
//          the whole frame, pulses START_IP_TXN, tracks the MAC stream to its
//          last beat and reports completion or a watchdog timeout.
// Ports:   ACLK, ARESET (async active-high); bus (slave modport) carries
//          requester handshake/fields, recipient outputs, START_IP_TXN,
//          READY_FOR_SEND, MAC stream monitor, TXN_DONE and error flag.
module ip_tx_arbiter
    import infernet_net_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic           ACLK,
    input logic           ARESET,
    ip_tx_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);

    tx_arb_state_t      state;
    tx_arb_state_t      state_next;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   grant_idx_q;
    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic [NUM_REQ-1:0] req_ready;
    logic               handshake;
    logic               last_beat;
    logic               wd_expired;
    recipient_t         winner;
    recipient_t         recipient_q;
    logic               start_q;
    logic [NUM_REQ-1:0] txn_done_q;
    logic               timeout_q;
    logic [WD_W-1:0]    watchdog;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_rr (
        .req       (bus.REQ_VALID),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    assign last_beat  = bus.MAC_DATA_VALID & bus.MAC_DATA_READY & bus.MAC_DATA_LAST;
    assign wd_expired = (watchdog == WD_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                winner.ip      = bus.REQ_IP_ADDRESS[i*IP_ADDR_WIDTH +: IP_ADDR_WIDTH];
                winner.mac     = bus.REQ_MAC_ADDRESS[i*MAC_ADDR_WIDTH +: MAC_ADDR_WIDTH];
                winner.message = bus.REQ_MESSAGE[i*ACCEL_DATA_WIDTH +: ACCEL_DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        handshake  = 1'b0;
        case (state)
            IDLE: begin
                // READY_FOR_SEND gates the grant so a still-busy transmitter
                // is never launched twice; ARESET keeps READY low in reset.
                if (bus.READY_FOR_SEND && arb_any && !ARESET) begin
                    req_ready = arb_grant;
                end
                handshake = |(bus.REQ_VALID & req_ready);
                if (handshake) begin
                    state_next = START;
                end
            end
            START: begin
                state_next = BUSY;
            end
            BUSY: begin
                if (last_beat || wd_expired) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rr_ptr      <= IDX_W'(NUM_REQ - 1);
            grant_idx_q <= '0;
            recipient_q <= '0;
            start_q     <= 1'b0;
            txn_done_q  <= '0;
            timeout_q   <= 1'b0;
            watchdog    <= '0;
        end else begin
            start_q    <= handshake;
            txn_done_q <= '0;
            if (handshake) begin
                recipient_q <= winner;
                grant_idx_q <= arb_idx;
                rr_ptr      <= arb_idx;
            end
            if (state == START) begin
                watchdog <= '0;
            end else if (state == BUSY) begin
                watchdog <= watchdog + 1'b1;
            end
            if (state == BUSY && last_beat) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (grant_idx_q == IDX_W'(i)) begin
                        txn_done_q[i] <= 1'b1;
                    end
                end
            end
            // A last beat in the expiry cycle completes the frame normally;
            // a fresh timeout overrides a simultaneous clear.
            if (state == BUSY && !last_beat && wd_expired) begin
                timeout_q <= 1'b1;
            end else if (bus.CLEAR_ERROR) begin
                timeout_q <= 1'b0;
            end
        end
    end

    assign bus.REQ_READY             = req_ready;
    assign bus.RECIPIENT_IP_ADDRESS  = recipient_q.ip;
    assign bus.RECIPIENT_MAC_ADDRESS = recipient_q.mac;
    assign bus.RECIPIENT_MESSAGE     = recipient_q.message;
    assign bus.START_IP_TXN          = start_q;
    assign bus.TXN_DONE              = txn_done_q;
    assign bus.TIMEOUT_ERROR         = timeout_q;

endmodule

// File: tb/tb_ip_tx_arbiter.sv
// tb/tb_ip_tx_arbiter.sv - scoreboard bench for ip_tx_arbiter
module tb_ip_tx_arbiter;
    import infernet_net_pkg::*;

    localparam int NREQ = 2;
    localparam int TMO  = 64;

    logic ACLK   = 1'b0;
    logic ARESET = 1'b1;

    always #5 ACLK = ~ACLK;

    ip_tx_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    ip_tx_arbiter #(
        .NUM_REQ        (NREQ),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .bus    (bus)
    );

    int              checks   = 0;
    int              failures = 0;
    recipient_t      exp_start_q[$];
    logic [NREQ-1:0] exp_done_q[$];
    int              done_cnt [NREQ];
    recipient_t      req_fields [NREQ];
    recipient_t      mon_e;
    logic [NREQ-1:0] mon_d;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic drive_fields(input bit junk);
        recipient_t r;
        for (int i = 0; i < NREQ; i++) begin
            r = req_fields[i];
            if (junk) r = ~r;
            bus.REQ_IP_ADDRESS[i*IP_ADDR_WIDTH +: IP_ADDR_WIDTH]        = r.ip;
            bus.REQ_MAC_ADDRESS[i*MAC_ADDR_WIDTH +: MAC_ADDR_WIDTH]     = r.mac;
            bus.REQ_MESSAGE[i*ACCEL_DATA_WIDTH +: ACCEL_DATA_WIDTH]     = r.message;
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT launches or completes.
    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (bus.START_IP_TXN) begin
                if (exp_start_q.size() == 0) begin
                    chk("start_unexpected", 64'(bus.START_IP_TXN), 64'd0);
                end else begin
                    mon_e = exp_start_q.pop_front();
                    chk("start_ip",  64'(bus.RECIPIENT_IP_ADDRESS),  64'(mon_e.ip));
                    chk("start_mac", 64'(bus.RECIPIENT_MAC_ADDRESS), 64'(mon_e.mac));
                    chk("start_msg", 64'(bus.RECIPIENT_MESSAGE),     64'(mon_e.message));
                end
            end
            if (bus.TXN_DONE != '0) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (bus.TXN_DONE[i]) done_cnt[i]++;
                end
                if (exp_done_q.size() == 0) begin
                    chk("done_unexpected", 64'(bus.TXN_DONE), 64'd0);
                end else begin
                    mon_d = exp_done_q.pop_front();
                    chk("txn_done", 64'(bus.TXN_DONE), 64'(mon_d));
                end
            end
        end
    end

    // Checks the one-hot grant now, issues the handshake and expects a
    // single START pulse in the following cycle.
    task automatic grant(input logic [NREQ-1:0] want, input bit push_done,
                         input logic [NREQ-1:0] valid_after, input string tag);
        int g;
        #1;
        chk({tag, "_ready"}, 64'(bus.REQ_READY), 64'(want));
        g = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (want[i]) g = i;
        end
        exp_start_q.push_back(req_fields[g]);
        if (push_done) exp_done_q.push_back(want);
        tick();
        chk({tag, "_start"}, 64'(bus.START_IP_TXN), 64'd1);
        chk({tag, "_ready_in_start"}, 64'(bus.REQ_READY), 64'd0);
        bus.REQ_VALID = valid_after;
    endtask

    // Transmitter model: n beats on the MAC stream, optional 50% backpressure,
    // optional ARESET at a given beat.
    task automatic do_frame(input int g, input int n, input bit bp, input int reset_at);
        int beats;
        int cyc;
        beats = 0;
        cyc   = 0;
        tick();
        chk("start_one_cycle", 64'(bus.START_IP_TXN), 64'd0);
        drive_fields(1'b1);
        while (beats < n && cyc < 400) begin
            if (beats == reset_at) begin
                bus.REQ_VALID = 2'b01;
                ARESET = 1'b1;
                #1;
                chk("rst_ready", 64'(bus.REQ_READY), 64'd0);
                chk("rst_start", 64'(bus.START_IP_TXN), 64'd0);
                chk("rst_ip",    64'(bus.RECIPIENT_IP_ADDRESS), 64'd0);
                chk("rst_mac",   64'(bus.RECIPIENT_MAC_ADDRESS), 64'd0);
                chk("rst_msg",   64'(bus.RECIPIENT_MESSAGE), 64'd0);
                chk("rst_done",  64'(bus.TXN_DONE), 64'd0);
                chk("rst_err",   64'(bus.TIMEOUT_ERROR), 64'd0);
                void'(exp_done_q.pop_back());
                bus.REQ_VALID = 2'b00;
                break;
            end
            chk("hold_ip",  64'(bus.RECIPIENT_IP_ADDRESS),  64'(req_fields[g].ip));
            chk("hold_mac", 64'(bus.RECIPIENT_MAC_ADDRESS), 64'(req_fields[g].mac));
            chk("hold_msg", 64'(bus.RECIPIENT_MESSAGE),     64'(req_fields[g].message));
            chk("busy_no_grant", 64'(bus.REQ_READY), 64'd0);
            bus.MAC_DATA_VALID = 1'b1;
            bus.MAC_DATA_READY = bp ? cyc[0] : 1'b1;
            bus.MAC_DATA_LAST  = (beats == n - 1);
            @(posedge ACLK);
            if (bus.MAC_DATA_VALID && bus.MAC_DATA_READY) beats++;
            #1;
            cyc++;
        end
        if (reset_at < 0) chk("frame_beats", 64'(beats), 64'(n));
        bus.MAC_DATA_VALID = 1'b0;
        bus.MAC_DATA_READY = 1'b0;
        bus.MAC_DATA_LAST  = 1'b0;
        drive_fields(1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL tb_watchdog: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        req_fields[0] = '{ip: 32'h0A00_0002, mac: 48'h1122_3344_5566, message: 10'h2A5};
        req_fields[1] = '{ip: 32'hC0A8_0107, mac: 48'hA1B2_C3D4_E5F6, message: 10'h15A};
        done_cnt[0] = 0;
        done_cnt[1] = 0;
        bus.REQ_VALID      = 2'b11;
        bus.READY_FOR_SEND = 1'b1;
        bus.MAC_DATA_VALID = 1'b0;
        bus.MAC_DATA_READY = 1'b0;
        bus.MAC_DATA_LAST  = 1'b0;
        bus.CLEAR_ERROR    = 1'b0;
        drive_fields(1'b0);

        // Reset state, with requests pending to prove READY is held low.
        repeat (3) tick();
        chk("reset_ready", 64'(bus.REQ_READY), 64'd0);
        chk("reset_start", 64'(bus.START_IP_TXN), 64'd0);
        chk("reset_ip",    64'(bus.RECIPIENT_IP_ADDRESS), 64'd0);
        chk("reset_done",  64'(bus.TXN_DONE), 64'd0);
        chk("reset_err",   64'(bus.TIMEOUT_ERROR), 64'd0);
        bus.REQ_VALID = 2'b00;
        ARESET = 1'b0;
        tick();
        chk("idle_no_start", 64'(bus.START_IP_TXN), 64'd0);
        chk("idle_no_ready", 64'(bus.REQ_READY), 64'd0);

        // Contention: both held for four frames, grants 0,1,0,1.
        bus.REQ_VALID = 2'b11;
        for (int f = 0; f < 4; f++) begin
            grant((f % 2 == 0) ? 2'b01 : 2'b10, 1'b1, (f == 3) ? 2'b00 : 2'b11, "cont");
            do_frame(f % 2, 36, 1'b0, -1);
        end
        tick();
        chk("cont_done_req0", 64'(done_cnt[0]), 64'd2);
        chk("cont_done_req1", 64'(done_cnt[1]), 64'd2);

        // Single request from requester 0.
        bus.REQ_VALID = 2'b01;
        grant(2'b01, 1'b1, 2'b00, "single");
        do_frame(0, 36, 1'b0, -1);
        tick();
        chk("single_hold_idle_ip", 64'(bus.RECIPIENT_IP_ADDRESS), 64'(req_fields[0].ip));

        // Backpressure: pointer at 0, so requester 1 wins; MAC ready toggles.
        bus.REQ_VALID = 2'b11;
        grant(2'b10, 1'b1, 2'b00, "bp");
        do_frame(1, 24, 1'b1, -1);

        // Timeout: no MAC activity; requester 1 waits behind the dead frame.
        bus.REQ_VALID = 2'b01;
        grant(2'b01, 1'b0, 2'b10, "tmo");
        for (int i = 1; i <= TMO; i++) tick();
        chk("tmo_err_before", 64'(bus.TIMEOUT_ERROR), 64'd0);
        chk("tmo_busy_ready", 64'(bus.REQ_READY), 64'd0);
        tick();
        chk("tmo_err_set", 64'(bus.TIMEOUT_ERROR), 64'd1);
        grant(2'b10, 1'b1, 2'b00, "after_tmo");
        do_frame(1, 36, 1'b0, -1);
        chk("err_sticky", 64'(bus.TIMEOUT_ERROR), 64'd1);
        bus.CLEAR_ERROR = 1'b1;
        tick();
        bus.CLEAR_ERROR = 1'b0;
        chk("err_cleared", 64'(bus.TIMEOUT_ERROR), 64'd0);

        // Transmitter busy blocks the grant.
        bus.READY_FOR_SEND = 1'b0;
        bus.REQ_VALID      = 2'b10;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rfs_low_ready", 64'(bus.REQ_READY), 64'd0);
        end
        bus.READY_FOR_SEND = 1'b1;
        grant(2'b10, 1'b1, 2'b00, "rfs");
        do_frame(1, 36, 1'b0, -1);

        // Reset mid-frame at beat 20 of a requester-0 frame; afterwards the
        // reset pointer gives requester 0 priority again.
        bus.REQ_VALID = 2'b01;
        grant(2'b01, 1'b1, 2'b00, "pre_rst");
        do_frame(0, 36, 1'b0, 20);
        tick();
        ARESET = 1'b0;
        bus.REQ_VALID = 2'b11;
        grant(2'b01, 1'b1, 2'b00, "post_rst");
        do_frame(0, 36, 1'b0, -1);

        repeat (2) tick();
        chk("sb_start_empty", 64'(exp_start_q.size()), 64'd0);
        chk("sb_done_empty",  64'(exp_done_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
